// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline constants: widths, writeback selects and load funct3 codes.
package mem_wb_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RAW   = 5;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: pipeline controls, MEM results in, register-file write port out.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN  = mem_wb_stage_pkg::XLEN,
  parameter int unsigned RAW   = mem_wb_stage_pkg::RAW,
  parameter int unsigned CNT_W = mem_wb_stage_pkg::CNT_W
);

  logic             stall;
  logic             flush;
  logic             in_valid;
  logic             in_reg_write;
  logic [RAW-1:0]   in_rd;
  logic [1:0]       in_wb_sel;
  logic [2:0]       in_ld_funct3;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_mem_rdata;
  logic [XLEN-1:0]  in_pc_plus4;
  logic [XLEN-1:0]  in_imm;

  logic             rf_we;
  logic [RAW-1:0]   rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             fwd_valid;
  logic             ld_misalign;
  logic [CNT_W-1:0] instret;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_ld_funct3,
           in_alu_result, in_mem_rdata, in_pc_plus4, in_imm,
    input  rf_we, rf_waddr, rf_wdata, fwd_valid, ld_misalign, instret
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_ld_funct3,
           in_alu_result, in_mem_rdata, in_pc_plus4, in_imm,
    output rf_we, rf_waddr, rf_wdata, fwd_valid, ld_misalign, instret
  );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment and misalignment detection for one memory word.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = mem_wb_stage_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend according to funct3.
  always_comb begin
    byte_sel = raw[{offset, 3'b000} +: 8];
    half_sel = raw[{offset[1], 4'b0000} +: 16];
    data     = '0;
    misalign = 1'b0;
    unique case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      F3_LW: begin
        data     = raw;
        misalign = (offset != 2'b00);
      end
      default: begin
        data     = '0;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: writeback select, load alignment, RF write port, retire count.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN  = mem_wb_stage_pkg::XLEN,
  parameter int unsigned RAW   = mem_wb_stage_pkg::RAW,
  parameter int unsigned CNT_W = mem_wb_stage_pkg::CNT_W
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  logic [XLEN-1:0]  ld_data;
  logic             ld_mis_raw;
  logic             mis_in;
  logic             we_in;
  logic [XLEN-1:0]  wdata_in;
  logic             retire;

  // Write enable and misalign flag are stored pre-qualified so outputs are flop-driven.
  logic             we_q;
  logic             mis_q;
  logic [RAW-1:0]   rd_q;
  logic [XLEN-1:0]  wdata_q;
  logic [CNT_W-1:0] instret_q;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3   (bus.in_ld_funct3),
    .offset   (bus.in_alu_result[1:0]),
    .raw      (bus.in_mem_rdata),
    .data     (ld_data),
    .misalign (ld_mis_raw)
  );

  // Writeback source select and next-cycle qualifiers, computed ahead of the register.
  always_comb begin
    wdata_in = '0;
    unique case (wb_sel_e'(bus.in_wb_sel))
      WB_ALU:  wdata_in = bus.in_alu_result;
      WB_MEM:  wdata_in = ld_data;
      WB_PC4:  wdata_in = bus.in_pc_plus4;
      WB_IMM:  wdata_in = bus.in_imm;
      default: wdata_in = '0;
    endcase
    mis_in = (wb_sel_e'(bus.in_wb_sel) == WB_MEM) & ld_mis_raw;
    we_in  = bus.in_valid & bus.in_reg_write & (bus.in_rd != '0) & ~mis_in;
    retire = bus.in_valid & ~mis_in & ~bus.stall & ~bus.flush;
  end

  // Pipeline register: reset, then bubble on flush, then hold on stall, else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else if (bus.flush) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!bus.stall) begin
      we_q    <= we_in;
      mis_q   <= bus.in_valid & mis_in;
      rd_q    <= bus.in_rd;
      wdata_q <= wdata_in;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.rf_we       = we_q;
  assign bus.fwd_valid   = we_q;
  assign bus.rf_waddr    = rd_q;
  assign bus.rf_wdata    = wdata_q;
  assign bus.ld_misalign = mis_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Table-driven bench for mem_wb_stage with a one-deep expected-result scoreboard.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if bus ();
  mem_wb_stage_if #(.CNT_W(2)) bus2 ();

  mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus));
  mem_wb_stage #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Small-counter copy sees the identical stimulus to exercise counter wrap.
  assign bus2.stall         = bus.stall;
  assign bus2.flush         = bus.flush;
  assign bus2.in_valid      = bus.in_valid;
  assign bus2.in_reg_write  = bus.in_reg_write;
  assign bus2.in_rd         = bus.in_rd;
  assign bus2.in_wb_sel     = bus.in_wb_sel;
  assign bus2.in_ld_funct3  = bus.in_ld_funct3;
  assign bus2.in_alu_result = bus.in_alu_result;
  assign bus2.in_mem_rdata  = bus.in_mem_rdata;
  assign bus2.in_pc_plus4   = bus.in_pc_plus4;
  assign bus2.in_imm        = bus.in_imm;

  typedef struct {
    logic        rst, stall, flush, valid, rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu, rdata, pc4, imm;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        chkd;
    logic        mis;
    logic        inc;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] cnt;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_cnt = '0;

  localparam logic [31:0] MW = 32'h8899_AABB;
  localparam logic [31:0] MP = 32'h1234_5678;

  function automatic vec_t mk(logic r, logic s, logic f, logic v, logic rw, logic [4:0] rd,
                              logic [1:0] sel, logic [2:0] f3, logic [31:0] alu,
                              logic [31:0] rdata, logic [31:0] pc4, logic [31:0] imm,
                              logic we, logic [4:0] waddr, logic [31:0] wdata,
                              logic chkd, logic mis, logic inc);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.valid = v; t.rw = rw; t.rd = rd;
    t.sel = sel; t.f3 = f3; t.alu = alu; t.rdata = rdata; t.pc4 = pc4; t.imm = imm;
    t.we = we; t.waddr = waddr; t.wdata = wdata; t.chkd = chkd; t.mis = mis; t.inc = inc;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, push its expectation, compare after the next rising edge.
  task automatic apply(vec_t v, int idx);
    exp_t e;
    bus.stall = v.stall; bus.flush = v.flush; rst = v.rst;
    bus.in_valid = v.valid; bus.in_reg_write = v.rw; bus.in_rd = v.rd;
    bus.in_wb_sel = v.sel; bus.in_ld_funct3 = v.f3; bus.in_alu_result = v.alu;
    bus.in_mem_rdata = v.rdata; bus.in_pc_plus4 = v.pc4; bus.in_imm = v.imm;
    if (v.rst) model_cnt = '0;
    else if (v.inc) model_cnt = model_cnt + 32'd1;
    e.v = v; e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    chk($sformatf("v%0d.rf_we", idx), 32'(bus.rf_we), 32'(e.v.we));
    chk($sformatf("v%0d.fwd_valid", idx), 32'(bus.fwd_valid), 32'(e.v.we));
    chk($sformatf("v%0d.ld_misalign", idx), 32'(bus.ld_misalign), 32'(e.v.mis));
    chk($sformatf("v%0d.instret", idx), bus.instret, e.cnt);
    chk($sformatf("v%0d.instret_w2", idx), 32'(bus2.instret), 32'(e.cnt[1:0]));
    if (e.v.chkd) begin
      chk($sformatf("v%0d.rf_waddr", idx), 32'(bus.rf_waddr), 32'(e.v.waddr));
      chk($sformatf("v%0d.rf_wdata", idx), bus.rf_wdata, e.v.wdata);
    end
  endtask

  initial begin
    //          rst s f v rw rd   sel    f3      alu           rdata pc4          imm            we wa   wdata          chkd mis inc
    tbl.push_back(mk(1,0,0,0,0, 0, 2'd0, 3'd0, 32'h0,        32'h0, 32'h0,       32'h0,          0, 0, 32'h0,          1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0, 0, 2'd0, 3'd0, 32'h0,        32'h0, 32'h0,       32'h0,          0, 0, 32'h0,          1, 0, 0));
    tbl.push_back(mk(0,0,0,1,1, 5, 2'd0, 3'd0, 32'h0000_1234,32'h0, 32'h0,       32'h0,          1, 5, 32'h0000_1234,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 1, 2'd1, F3_LB, 32'd3,       MW,    32'h0,       32'h0,          1, 1, 32'hFFFF_FF88,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 2, 2'd1, F3_LBU,32'd0,       MW,    32'h0,       32'h0,          1, 2, 32'h0000_00BB,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 3, 2'd1, F3_LH, 32'd2,       MW,    32'h0,       32'h0,          1, 3, 32'hFFFF_8899,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 4, 2'd1, F3_LHU,32'd0,       MW,    32'h0,       32'h0,          1, 4, 32'h0000_AABB,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 6, 2'd1, F3_LW, 32'd0,       MW,    32'h0,       32'h0,          1, 6, 32'h8899_AABB,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 7, 2'd1, F3_LW, 32'd2,       MW,    32'h0,       32'h0,          0, 7, 32'h0,          0, 1, 0));
    tbl.push_back(mk(0,0,0,1,1, 7, 2'd1, F3_LH, 32'd1,       MW,    32'h0,       32'h0,          0, 7, 32'h0,          0, 1, 0));
    tbl.push_back(mk(0,0,0,1,1, 0, 2'd3, 3'd0, 32'h0,        MW,    32'h0,       32'hDEAD_0000,  0, 0, 32'hDEAD_0000,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, F3_LBU,32'd1,       MW,    32'h0,       32'h0,          1, 8, 32'h0000_00AA,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, F3_LB, 32'd0,       MW,    32'h0,       32'h0,          1, 8, 32'hFFFF_FFBB,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, F3_LHU,32'd2,       MW,    32'h0,       32'h0,          1, 8, 32'h0000_8899,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, F3_LB, 32'd0,       MP,    32'h0,       32'h0,          1, 8, 32'h0000_0078,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, F3_LH, 32'd2,       MP,    32'h0,       32'h0,          1, 8, 32'h0000_1234,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, 3'b011,32'd0,       MW,    32'h0,       32'h0,          1, 8, 32'h0,          1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1, 8, 2'd1, 3'b110,32'd3,       MW,    32'h0,       32'h0,          1, 8, 32'h0,          1, 0, 1));
    tbl.push_back(mk(0,0,0,1,1,31, 2'd2, 3'd0, 32'h0,        MW,    32'h0000_0104,32'h0,         1,31, 32'h0000_0104,  1, 0, 1));
    tbl.push_back(mk(0,0,0,1,0, 5, 2'd0, 3'd0, 32'h55,       MW,    32'h0,       32'h0,          0, 5, 32'h55,         1, 0, 1));
    tbl.push_back(mk(0,0,0,0,1, 5, 2'd0, 3'd0, 32'h66,       MW,    32'h0,       32'h0,          0, 5, 32'h66,         1, 0, 0));
    // stall sequence: rd=9 held for three stalled cycles, then flush+stall, then flush
    tbl.push_back(mk(0,0,0,1,1, 9, 2'd0, 3'd0, 32'h99,       MW,    32'h0,       32'h0,          1, 9, 32'h99,         1, 0, 1));
    tbl.push_back(mk(0,1,0,1,1,10, 2'd0, 3'd0, 32'hAA,       MW,    32'h0,       32'h0,          1, 9, 32'h99,         1, 0, 0));
    tbl.push_back(mk(0,1,0,1,1,10, 2'd0, 3'd0, 32'hAA,       MW,    32'h0,       32'h0,          1, 9, 32'h99,         1, 0, 0));
    tbl.push_back(mk(0,1,0,1,1,10, 2'd0, 3'd0, 32'hAA,       MW,    32'h0,       32'h0,          1, 9, 32'h99,         1, 0, 0));
    tbl.push_back(mk(0,1,1,1,1,11, 2'd0, 3'd0, 32'hBB,       MW,    32'h0,       32'h0,          0, 0, 32'h0,          0, 0, 0));
    tbl.push_back(mk(0,0,1,1,1,11, 2'd0, 3'd0, 32'hBB,       MW,    32'h0,       32'h0,          0, 0, 32'h0,          0, 0, 0));
    // misaligned load then flush clears the flag
    tbl.push_back(mk(0,0,0,1,1, 7, 2'd1, F3_LW, 32'd1,       MW,    32'h0,       32'h0,          0, 7, 32'h0,          0, 1, 0));
    tbl.push_back(mk(0,0,1,1,1, 7, 2'd1, F3_LW, 32'd1,       MW,    32'h0,       32'h0,          0, 7, 32'h0,          0, 0, 0));
    // reset with a pending write discards it; reset beats stall and flush
    tbl.push_back(mk(0,0,0,1,1,12, 2'd0, 3'd0, 32'h5,        MW,    32'h0,       32'h0,          1,12, 32'h5,          1, 0, 1));
    tbl.push_back(mk(1,0,0,1,1,13, 2'd0, 3'd0, 32'h7,        MW,    32'h0,       32'h0,          0, 0, 32'h0,          1, 0, 0));
    tbl.push_back(mk(0,0,0,1,1,14, 2'd0, 3'd0, 32'h8,        MW,    32'h0,       32'h0,          1,14, 32'h8,          1, 0, 1));
    tbl.push_back(mk(1,1,1,1,1,15, 2'd0, 3'd0, 32'h9,        MW,    32'h0,       32'h0,          0, 0, 32'h0,          1, 0, 0));

    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_reg_write = 1'b0;
    bus.in_rd = '0; bus.in_wb_sel = '0; bus.in_ld_funct3 = '0; bus.in_alu_result = '0;
    bus.in_mem_rdata = '0; bus.in_pc_plus4 = '0; bus.in_imm = '0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Wrap sequence: after reset, five retirements step the 2-bit counter 1,2,3,0,1.
    apply(mk(1,0,0,0,0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0), 100);
    for (int k = 1; k <= 5; k++) begin
      apply(mk(0,0,0,1,1, 5'(k), 2'd0, 3'd0, 32'(k), 32'h0, 32'h0, 32'h0,
               1, 5'(k), 32'(k), 1, 0, 1), 100 + k);
      chk($sformatf("wrap%0d", k), 32'(bus2.instret), 32'(k % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
